req_conditioner: RTL and testbench

Upstream request-conditioning stage for the 4-agent grant FSM. It converts single-cycle request pulses from agents 0–3 into the level-held `req[i]` lines the arbiter expects. Each `req[i]` is held until the agent signals `done[i]`, then dropped until the arbiter withdraws `gnt[i]`. Up to 2^CNT_W−1 requests are queued per agent, and long-waiting agents are flagged as starved.

---
 rtl/req_cond_pkg.sv | 17 +
 rtl/req_cond_agent.sv | 130 +++++++++++++
 rtl/req_conditioner.sv | 43 ++++
 tb/tb_req_conditioner.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/req_cond_pkg.sv
// req_cond_pkg: shared state encoding and defaults for the request conditioner.
// Optional starvation tracking is enabled with REQ_COND_STARVE_EN.
package req_cond_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        ACTIVE = 2'd2,
        DROP   = 2'd3
    } agent_state_e;

    localparam int NUM_AGENTS       = 4;
    localparam int DEF_CNT_W        = 2;
    localparam int DEF_AGE_W        = 8;
    localparam int DEF_STARVE_LIMIT = 200;

endpackage

// File: rtl/req_cond_agent.sv
// req_cond_agent: one agent's pulse-to-level FSM, request queue and wait age.
// Age counter and starve flag exist only when REQ_COND_STARVE_EN is defined.
module req_cond_agent
    import req_cond_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
`ifdef REQ_COND_STARVE_EN
    ,
    parameter int AGE_W        = DEF_AGE_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
`endif
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req_pulse,
    input  logic i_done,
    input  logic i_gnt,
    output logic o_req,
    output logic o_starve,
    output logic o_overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    agent_state_e     r_state;
    agent_state_e     w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_req;
    logic             r_ovf;
    logic             w_full;
    logic             w_dec;
    logic             w_inc;
    logic             w_drop_pulse;

    assign w_full       = (r_cnt == CNT_MAX);
    assign w_dec        = (r_state == PEND) && i_gnt;
    assign w_inc        = i_req_pulse && (!w_full || w_dec);
    assign w_drop_pulse = i_req_pulse && w_full && !w_dec;

    // queue depth: a simultaneous accept and grant leave it unchanged
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_inc && !w_dec) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end else if (w_dec && !w_inc) begin
            w_cnt_nxt = r_cnt - CNT_ONE;
        end
    end

    // next state; DROP exit looks at the updated depth so a same-cycle pulse is kept
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_inc) begin
                    w_state_nxt = PEND;
                end
            end
            PEND: begin
                if (i_gnt) begin
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (i_done) begin
                    w_state_nxt = DROP;
                end
            end
            DROP: begin
                if (!i_gnt) begin
                    w_state_nxt = (w_cnt_nxt != '0) ? PEND : IDLE;
                end
            end
        endcase
    end

    // state, depth, registered req level and sticky overflow
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_req   <= (w_state_nxt == PEND) || (w_state_nxt == ACTIVE);
            r_ovf   <= r_ovf | w_drop_pulse;
        end
    end

    assign o_req      = r_req;
    assign o_overflow = r_ovf;

`ifdef REQ_COND_STARVE_EN
    localparam logic [AGE_W-1:0] AGE_MAX   = '1;
    localparam logic [AGE_W-1:0] AGE_ONE   = AGE_W'(1);
    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(STARVE_LIMIT);

    logic [AGE_W-1:0] r_age;
    logic [AGE_W-1:0] w_age_nxt;
    logic             r_starve;

    // age runs only while staying in PEND and saturates at its maximum
    always_comb begin
        w_age_nxt = '0;
        if (r_state == PEND && w_state_nxt == PEND) begin
            w_age_nxt = (r_age == AGE_MAX) ? r_age : r_age + AGE_ONE;
        end
    end

    // age register and its registered threshold flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_age    <= '0;
            r_starve <= 1'b0;
        end else begin
            r_age    <= w_age_nxt;
            r_starve <= (w_age_nxt >= AGE_LIMIT);
        end
    end

    assign o_starve = r_starve;
`else
    assign o_starve = 1'b0;
`endif

endmodule

// File: rtl/req_conditioner.sv
// req_conditioner: turns per-agent request pulses into held req levels.
// Define REQ_COND_STARVE_EN to build the wait-age counters and starve flags.
module req_conditioner
    import req_cond_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
`ifdef REQ_COND_STARVE_EN
    ,
    parameter int AGE_W        = DEF_AGE_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_AGENTS-1:0] req_pulse,
    input  logic [NUM_AGENTS-1:0] done,
    input  logic [NUM_AGENTS-1:0] gnt,
    output logic [NUM_AGENTS-1:0] req,
    output logic [NUM_AGENTS-1:0] starve,
    output logic [NUM_AGENTS-1:0] overflow
);

    for (genvar g = 0; g < NUM_AGENTS; g++) begin : g_agent
        req_cond_agent #(
            .CNT_W(CNT_W)
`ifdef REQ_COND_STARVE_EN
            ,
            .AGE_W(AGE_W),
            .STARVE_LIMIT(STARVE_LIMIT)
`endif
        ) u_agent (
            .i_clk      (clock),
            .i_rst      (reset),
            .i_req_pulse(req_pulse[g]),
            .i_done     (done[g]),
            .i_gnt      (gnt[g]),
            .o_req      (req[g]),
            .o_starve   (starve[g]),
            .o_overflow (overflow[g])
        );
    end

endmodule

// File: tb/tb_req_conditioner.sv
// tb_req_conditioner: directed and random stimulus against a transaction model.
// Starve expectations follow REQ_COND_STARVE_EN.
module tb_req_conditioner;
    import req_cond_pkg::*;

    localparam int MAXQ    = (1 << DEF_CNT_W) - 1;
    localparam int AGE_SAT = (1 << DEF_AGE_W) - 1;
`ifdef REQ_COND_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] req_pulse;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [3:0] req;
    logic [3:0] starve;
    logic [3:0] overflow;

    always #5 clock = ~clock;

    req_conditioner dut (
        .clock    (clock),
        .reset    (reset),
        .req_pulse(req_pulse),
        .done     (done),
        .gnt      (gnt),
        .req      (req),
        .starve   (starve),
        .overflow (overflow)
    );

    int total = 0;
    int bad   = 0;

    // transaction model: queued count, and which part of a transaction the agent is in
    int owed[4];
    int age[4];
    bit waiting[4];
    bit busy[4];
    bit cooling[4];
    bit ovf[4];

    task automatic check_eq(input string tag, input logic [3:0] got,
                            input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit granting;
        bit accept;
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                owed[i] = 0; age[i] = 0; ovf[i] = 0;
                waiting[i] = 0; busy[i] = 0; cooling[i] = 0;
            end else begin
                granting = waiting[i] && gnt[i];
                accept   = req_pulse[i] && (owed[i] < MAXQ || granting);
                if (req_pulse[i] && !accept) ovf[i] = 1;
                owed[i] = owed[i] + int'(accept) - int'(granting);
                if (waiting[i]) begin
                    if (gnt[i]) begin
                        waiting[i] = 0; busy[i] = 1; age[i] = 0;
                    end else if (age[i] < AGE_SAT) begin
                        age[i]++;
                    end
                end else if (busy[i]) begin
                    if (done[i]) begin
                        busy[i] = 0; cooling[i] = 1;
                    end
                end else if (cooling[i]) begin
                    if (!gnt[i]) begin
                        cooling[i] = 0; waiting[i] = (owed[i] > 0);
                    end
                end else if (accept) begin
                    waiting[i] = 1;
                end
            end
        end
    endtask

    function automatic logic [3:0] m_req();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = waiting[i] | busy[i];
        return v;
    endfunction

    function automatic logic [3:0] m_starve();
        logic [3:0] v;
        for (int i = 0; i < 4; i++)
            v[i] = STARVE_ON && waiting[i] && (age[i] >= DEF_STARVE_LIMIT);
        return v;
    endfunction

    function automatic logic [3:0] m_ovf();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = ovf[i];
        return v;
    endfunction

    task automatic cyc(input string tag, input logic r, input logic [3:0] p,
                       input logic [3:0] d, input logic [3:0] g);
        reset = r; req_pulse = p; done = d; gnt = g;
        @(posedge clock);
        model_step();
        #1;
        check_eq({tag, "/req"}, req, m_req());
        check_eq({tag, "/starve"}, starve, m_starve());
        check_eq({tag, "/ovf"}, overflow, m_ovf());
    endtask

    initial begin
        reset = 1'b1; req_pulse = '0; done = '0; gnt = '0;

        for (int k = 0; k < 3; k++) cyc("rst", 1'b1, 4'hF, 4'h0, 4'h0);
        check_eq("rst_req", req, 4'h0);
        cyc("rel", 1'b0, 4'hF, 4'h0, 4'h0);
        check_eq("rel_req", req, 4'hF);
        cyc("rst", 1'b1, 4'h0, 4'h0, 4'h0);

        cyc("a1", 1'b0, 4'b0010, 4'h0, 4'h0);
        check_eq("a1_req", req, 4'b0010);
        cyc("a1", 1'b0, 4'h0, 4'h0, 4'h0);
        for (int k = 0; k < 5; k++) cyc("a1g", 1'b0, 4'h0, 4'h0, 4'b0010);
        cyc("a1d", 1'b0, 4'h0, 4'b0010, 4'b0010);
        check_eq("a1_drop", req, 4'h0);
        cyc("a1h", 1'b0, 4'h0, 4'h0, 4'b0010);
        cyc("a1l", 1'b0, 4'h0, 4'h0, 4'h0);
        cyc("a1i", 1'b0, 4'h0, 4'h0, 4'h0);
        check_eq("a1_idle", req, 4'h0);

        for (int k = 0; k < 4; k++) cyc("a2p", 1'b0, 4'b0100, 4'h0, 4'h0);
        check_eq("a2_ovf", overflow, 4'b0100);
        for (int k = 0; k < 3; k++) begin
            cyc("a2g", 1'b0, 4'h0, 4'h0, 4'b0100);
            cyc("a2d", 1'b0, 4'h0, 4'b0100, 4'b0100);
            cyc("a2l", 1'b0, 4'h0, 4'h0, 4'h0);
        end
        cyc("a2i", 1'b0, 4'h0, 4'h0, 4'h0);
        check_eq("a2_end", req, 4'h0);
        cyc("rst", 1'b1, 4'h0, 4'h0, 4'h0);

        cyc("a3p", 1'b0, 4'b1000, 4'h0, 4'h0);
        for (int k = 0; k < 250; k++) cyc("a3w", 1'b0, 4'h0, 4'h0, 4'h0);
        check_eq("a3_starve", starve, STARVE_ON ? 4'b1000 : 4'b0000);
        cyc("a3g", 1'b0, 4'h0, 4'h0, 4'b1000);
        check_eq("a3_clear", starve, 4'h0);
        cyc("rst", 1'b1, 4'h0, 4'h0, 4'h0);

        for (int k = 0; k < 3; k++) cyc("a0p", 1'b0, 4'b0001, 4'h0, 4'h0);
        cyc("a0pg", 1'b0, 4'b0001, 4'h0, 4'b0001);
        check_eq("a0_noovf", overflow, 4'h0);
        cyc("a0d", 1'b0, 4'h0, 4'b0001, 4'b0001);
        cyc("a0l", 1'b0, 4'h0, 4'h0, 4'h0);
        cyc("a0dp", 1'b0, 4'h0, 4'b0001, 4'h0);
        check_eq("a0_dpend", req, 4'b0001);
        cyc("a0g", 1'b0, 4'h0, 4'h0, 4'b0001);
        cyc("a0r", 1'b1, 4'h0, 4'h0, 4'b0001);
        check_eq("a0_rst", req, 4'h0);
        cyc("a0e", 1'b0, 4'h0, 4'h0, 4'h0);
        cyc("a0e", 1'b0, 4'h0, 4'h0, 4'h0);
        check_eq("a0_empty", req, 4'h0);

        for (int k = 0; k < 3000; k++) begin
            logic [3:0] p;
            logic [3:0] d;
            logic [3:0] g;
            g = gnt;
            for (int i = 0; i < 4; i++) begin
                p[i] = ($urandom_range(0, 3) == 0);
                d[i] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 5) == 0) g[i] = ~g[i];
            end
            cyc("rnd", ($urandom_range(0, 499) == 0), p, d, g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
